// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input framer.
//   N, LOGN : frame length in samples and its log2
//   WIDTH   : bits per component (Q16.16 two's complement, WIDTH_F fractional bits)
//   GAP     : minimum idle cycles between a frame's last sample and the next start pulse
//   rd_state_t : read-side FSM states
package fft_pkg;
    localparam int N       = 256;
    localparam int LOGN    = 8;
    localparam int WIDTH   = 32;
    localparam int WIDTH_F = 16;
    localparam int GAP     = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } rd_state_t;
endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port, registered read
// (data appears the cycle after the address). Address MSB selects the bank.
//   clk   : clock
//   we    : write enable
//   waddr : write address {bank, index}
//   wdata : write data {re, im}
//   raddr : read address {bank, index}
//   rdata : read data, one cycle after raddr
module fft_frame_ram #(
    parameter int AW = 9,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_in_framer.sv
// Buffers a bursty valid/ready complex sample stream into a ping-pong RAM and
// replays each complete frame to the FFT core as a one-cycle start pulse
// followed by N back-to-back samples.
//   clk, rst   : clock, asynchronous active-high reset
//   s_valid    : input sample valid
//   s_ready    : framer can accept a sample (registered)
//   s_re, s_im : input sample
//   fft_vld_in : frame start pulse
//   fft_x_r/_i : frame samples, zero outside the streaming window
//   frame_cnt  : frames emitted since reset (wraps)
module fft_in_framer
    import fft_pkg::*;
#(
    parameter int N     = fft_pkg::N,
    parameter int LOGN  = fft_pkg::LOGN,
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int GAP   = fft_pkg::GAP    // up to 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_re,
    input  logic [WIDTH-1:0] s_im,
    output logic             fft_vld_in,
    output logic [WIDTH-1:0] fft_x_r,
    output logic [WIDTH-1:0] fft_x_i,
    output logic [15:0]      frame_cnt
);
    logic [LOGN-1:0]    wr_cnt, rd_cnt;
    logic               wr_sel, rd_sel;
    logic [1:0]         full, full_nxt;
    logic               accept, wr_last, rd_done;
    rd_state_t          state;
    logic [7:0]         gap_cnt;
    logic [2*WIDTH-1:0] rd_data;

    assign accept  = s_valid && s_ready;
    assign wr_last = accept && (wr_cnt == LOGN'(N - 1));
    // rd_cnt runs one ahead of the output sample, so it wraps to 0 on the last one
    assign rd_done = (state == S_STREAM) && (rd_cnt == '0);

    // Writer and reader never own the same bank, so set and clear never collide
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rd_sel] = 1'b0;
        if (wr_last) full_nxt[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_sel  <= 1'b0;
            full    <= '0;
            s_ready <= 1'b0;
        end else begin
            full    <= full_nxt;
            // ready reflects the bank the writer will own next cycle
            s_ready <= !full_nxt[wr_sel ^ wr_last];
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) wr_sel <= ~wr_sel;
            end
        end
    end

    fft_frame_ram #(.AW(LOGN + 1), .DW(2 * WIDTH)) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wr_sel, wr_cnt}),
        .wdata ({s_re, s_im}),
        .raddr ({rd_sel, rd_cnt}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_sel     <= 1'b0;
            rd_cnt     <= '0;
            gap_cnt    <= '0;
            fft_vld_in <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (full[rd_sel]) begin
                    state      <= S_START;
                    fft_vld_in <= 1'b1;
                end
                S_START: begin
                    // address 0 is on the RAM this cycle; sample 0 lands next cycle
                    fft_vld_in <= 1'b0;
                    rd_cnt     <= rd_cnt + 1'b1;
                    state      <= S_STREAM;
                end
                S_STREAM: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_done) begin
                        rd_cnt    <= '0;
                        rd_sel    <= ~rd_sel;
                        frame_cnt <= frame_cnt + 16'd1;
                        gap_cnt   <= '0;
                        state     <= (GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    // leave straight to START when a frame waits, keeping N+1+GAP throughput
                    if (gap_cnt == 8'(GAP - 1)) begin
                        if (full[rd_sel]) begin
                            state      <= S_START;
                            fft_vld_in <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM output has no reset; gating by state keeps outputs zero (and async-cleared)
    assign fft_x_r = (state == S_STREAM) ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign fft_x_i = (state == S_STREAM) ? rd_data[WIDTH-1:0]       : '0;
endmodule

// File: tb/tb_fft_in_framer.sv
module tb_fft_in_framer;
    import fft_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, s_valid = 1'b0;
    logic        s_ready, fft_vld_in;
    logic [31:0] s_re = '0, s_im = '0, fft_x_r, fft_x_i;
    logic [15:0] frame_cnt;

    fft_in_framer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .fft_vld_in(fft_vld_in),
        .fft_x_r(fft_x_r), .fft_x_i(fft_x_i), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: accepted-but-not-emitted samples in order; frames leave whole.
    logic [63:0] inq[$];
    int          out_idx = -1, since_last = GAP + 1, avail_wait = 0;
    int          pulses = 0, frames_out = 0;
    bit          ready_at_end = 0, fc_hold = 0;
    logic [15:0] model_fc = '0;

    always @(negedge clk) begin : compare
        logic [63:0] e;
        bit avail;
        if (rst) begin
            chk("rst_data", 64'({fft_x_r, fft_x_i}), 64'd0);
            chk("rst_ctl", 64'({fft_vld_in, s_ready, frame_cnt}), 64'd0);
            inq.delete();
            out_idx = -1; since_last = GAP + 1; avail_wait = 0;
            ready_at_end = 0; model_fc = '0;
        end else begin
            if (fc_hold) model_fc = 16'hFFFF;
            else chk("frame_cnt", 64'(frame_cnt), 64'(model_fc));
            if (out_idx >= 0) begin
                if (inq.size() == 0) begin
                    chk("underrun", 64'd0, 64'd1);
                    e = '0;
                end else e = inq.pop_front();
                chk("x_r", 64'(fft_x_r), 64'(e[63:32]));
                chk("x_i", 64'(fft_x_i), 64'(e[31:0]));
                chk("vld_in_stream", 64'(fft_vld_in), 64'd0);
                out_idx++;
                if (out_idx == N) begin
                    out_idx = -1; frames_out++; model_fc++;
                    since_last = 0; ready_at_end = (inq.size() >= N);
                end
            end else begin
                chk("idle_zero", 64'({fft_x_r, fft_x_i}), 64'd0);
                if (since_last < 100000) since_last++;
                avail = (inq.size() >= N) && (since_last > GAP);
                if (ready_at_end && since_last == GAP + 1)
                    chk("gap_exact", 64'(fft_vld_in), 64'd1);
                if (fft_vld_in) begin
                    chk("pulse_allowed", 64'(avail), 64'd1);
                    pulses++; out_idx = 0; avail_wait = 0; ready_at_end = 0;
                end else if (avail) begin
                    avail_wait++;
                    chk("pulse_latency", 64'(avail_wait < 2), 64'd1);
                end else avail_wait = 0;
            end
            if (s_valid && s_ready) inq.push_back({s_re, s_im});
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input logic [31:0] re, input logic [31:0] im, input int pct);
        bit acc = 0;
        int budget = 4000;
        while ($urandom_range(99) >= pct) begin @(posedge clk); #1; end
        s_valid = 1'b1; s_re = re; s_im = im;
        while (!acc && budget > 0) begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1; budget--;
        end
        s_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_frames(input int k);
        int b = 20000;
        while (frames_out < k && b > 0) begin @(negedge clk); b--; end
        chk("wait_frames", 64'(frames_out >= k), 64'd1);
        @(posedge clk); #1;
    endtask

    // Returns at the negedge of the start-pulse cycle.
    task automatic wait_pulse();
        int b = 5000;
        bit got = 0;
        while (!got && b > 0) begin @(negedge clk); got = fft_vld_in; b--; end
        chk("wait_pulse", 64'(got), 64'd1);
    endtask

    logic [31:0] ext [3];

    initial begin
        int base, p0, b;
        ext[0] = 32'h7FFF_FFFF; ext[1] = 32'h8000_0000; ext[2] = 32'h0000_0001;

        // 1: reset
        repeat (5) @(posedge clk);
        @(negedge clk); chk("t1_ready_rst", 64'(s_ready), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        #1 chk("t1_ready_pre", 64'(s_ready), 64'd0);
        @(posedge clk); #1; chk("t1_ready_post", 64'(s_ready), 64'd1);
        repeat (1000) @(posedge clk);
        #1 chk("t1_no_pulse", 64'(pulses), 64'd0);

        // 2: one continuous frame, hand-checked samples
        for (int n = 0; n < N; n++) send(32'(n), 32'(-n), 100);
        wait_pulse();
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            if (n == 0)   chk("t2_s0", 64'({fft_x_r, fft_x_i}), 64'h0000_0000_0000_0000);
            if (n == 1)   chk("t2_s1", 64'({fft_x_r, fft_x_i}), 64'h0000_0001_FFFF_FFFF);
            if (n == 128) chk("t2_s128", 64'({fft_x_r, fft_x_i}), 64'h0000_0080_FFFF_FF80);
            if (n == 255) chk("t2_s255", 64'({fft_x_r, fft_x_i}), 64'h0000_00FF_FFFF_FF01);
        end
        @(negedge clk);
        chk("t2_fcnt", 64'(frame_cnt), 64'd1);
        chk("t2_pulses", 64'(pulses), 64'd1);
        @(posedge clk); #1;

        // 3: sustained input into backpressure
        base = frames_out;
        for (int n = 0; n < 512; n++) send(32'(n + 5000), 32'(n * 3), 100);
        @(negedge clk); chk("t3_ready_low", 64'(s_ready), 64'd0);
        b = 2000;
        while (!s_ready && b > 0) begin @(negedge clk); b--; end
        chk("t3_ready_back", 64'(s_ready), 64'd1);
        chk("t3_frames_at_ready", 64'(frames_out), 64'(base + 1));
        @(posedge clk); #1;
        for (int n = 512; n < 768; n++) send(32'(n + 5000), 32'(n * 3), 100);
        wait_frames(base + 3);
        chk("t3_drained", 64'(inq.size()), 64'd0);

        // 4: bursty random input
        base = frames_out;
        for (int n = 0; n < 4 * N; n++) send($urandom, $urandom, 50);
        wait_frames(base + 4);

        // 5: reset mid-stream
        for (int n = 0; n < N; n++) send(32'(1000 + n), ~32'(n), 100);
        wait_pulse();
        repeat (101) @(posedge clk);
        #1 chk("t5_s100", 64'(fft_x_r), 64'd1100);
        #1 rst = 1'b1;
        #1 chk("t5_async_clr", 64'({fft_vld_in, fft_x_r, fft_x_i}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        p0 = pulses; base = frames_out;
        for (int n = 0; n < 100; n++) send(32'(2000 + n), 32'(n), 100);
        repeat (300) @(posedge clk);
        #1 chk("t5_partial_no_pulse", 64'(pulses), 64'(p0));
        for (int n = 100; n < N; n++) send(32'(2000 + n), 32'(n), 100);
        wait_frames(base + 1);
        @(negedge clk);
        chk("t5_one_pulse", 64'(pulses), 64'(p0 + 1));
        chk("t5_fcnt", 64'(frame_cnt), 64'd1);
        @(posedge clk); #1;

        // 6: extreme values and frame_cnt wrap
        fc_hold = 1;
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt;
        @(posedge clk); #1;
        fc_hold = 0;
        base = frames_out;
        for (int n = 0; n < N; n++) send(ext[n % 3], ext[(n + 1) % 3], 100);
        wait_pulse();
        @(negedge clk); chk("t6_s0", 64'({fft_x_r, fft_x_i}), 64'h7FFF_FFFF_8000_0000);
        @(negedge clk); chk("t6_s1", 64'({fft_x_r, fft_x_i}), 64'h8000_0000_0000_0001);
        @(negedge clk); chk("t6_s2", 64'({fft_x_r, fft_x_i}), 64'h0000_0001_7FFF_FFFF);
        wait_frames(base + 1);
        @(negedge clk); chk("t6_wrap", 64'(frame_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
